// File: rtl/ex_wb_stage.sv
`default_nettype none
// ============================================================================
// Module      : ex_wb_stage
// Description : Execute/writeback stage of the 8-bit slice CPU. Accepts one
//               decoded operation with its operand values, computes the
//               result (single cycle for ALU ops, iterative shift-add for
//               MUL), issues exactly one registered writeback pulse to the
//               register file and updates the Z/C flags.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk       - single clock, rising edge
//   rst_n     - synchronous reset, active-low
//   in_valid  - upstream presents an operation
//   in_ready  - stage can accept (transfer on in_valid && in_ready)
//   op        - 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL,
//               110 MUL, 111 MOV
//   rd_addr   - destination register
//   a, b      - operand values (rs1_data, rs2_data)
//   wb_we     - register-file write enable, one-cycle pulse
//   wb_addr   - register-file write address
//   wb_data   - register-file write data
//   busy      - MUL iteration in progress
//   flag_z    - last written result was zero
//   flag_c    - carry/borrow/overflow of last written result
// ============================================================================
module ex_wb_stage #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        op,
  input  logic [1:0]        rd_addr,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              wb_we,
  output logic [1:0]        wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic              busy,
  output logic              flag_z,
  output logic              flag_c
);

  localparam int ACC_W = 2 * DATA_W;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;
  localparam logic [2:0] OP_MOV = 3'b111;

  // Counter value during the final multiply iteration.
  localparam logic [CNT_W-1:0] C_LAST_ITER = CNT_W'(DATA_W - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  state_t              state_q,   state_d;
  logic [DATA_W-1:0]   mcand_q,   mcand_d;
  logic [DATA_W-1:0]   mplier_q,  mplier_d;
  logic [CNT_W-1:0]    cnt_q,     cnt_d;
  logic [ACC_W-1:0]    acc_q,     acc_d;
  logic [1:0]          dst_q,     dst_d;
  logic                wb_we_q,   wb_we_d;
  logic [1:0]          wb_addr_q, wb_addr_d;
  logic [DATA_W-1:0]   wb_data_q, wb_data_d;
  logic                flag_z_q,  flag_z_d;
  logic                flag_c_q,  flag_c_d;

  // --------------------------------------------------------------------------
  // Single-cycle ALU
  // --------------------------------------------------------------------------
  logic [DATA_W:0]     w_sum;
  logic [DATA_W:0]     w_diff;
  logic [ACC_W-1:0]    w_shl;
  logic [DATA_W-1:0]   w_alu_res;
  logic                w_alu_c;

  always_comb begin
    w_sum     = {1'b0, a} + {1'b0, b};
    // Extra MSB of the widened difference is the unsigned borrow.
    w_diff    = {1'b0, a} - {1'b0, b};
    // Shifting into a double-width vector keeps the shifted-out bits; the
    // last one to leave the low half always lands at bit DATA_W.
    w_shl     = {{DATA_W{1'b0}}, a} << b[2:0];
    w_alu_res = '0;
    w_alu_c   = 1'b0;
    case (op)
      OP_ADD: begin
        w_alu_res = w_sum[DATA_W-1:0];
        w_alu_c   = w_sum[DATA_W];
      end
      OP_SUB: begin
        w_alu_res = w_diff[DATA_W-1:0];
        w_alu_c   = w_diff[DATA_W];
      end
      OP_AND: w_alu_res = a & b;
      OP_OR:  w_alu_res = a | b;
      OP_XOR: w_alu_res = a ^ b;
      OP_SHL: begin
        w_alu_res = w_shl[DATA_W-1:0];
        w_alu_c   = (b[2:0] != 3'd0) ? w_shl[DATA_W] : 1'b0;
      end
      OP_MOV: w_alu_res = b;
      default: begin
        w_alu_res = '0;
        w_alu_c   = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Shift-add multiply step
  // --------------------------------------------------------------------------
  logic [ACC_W-1:0] w_addend;
  logic [ACC_W-1:0] w_acc_next;

  always_comb begin
    w_addend   = mplier_q[0] ? ({{DATA_W{1'b0}}, mcand_q} << cnt_q) : '0;
    w_acc_next = acc_q + w_addend;
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    dst_d     = dst_q;
    wb_we_d   = 1'b0;
    wb_addr_d = wb_addr_q;
    wb_data_d = wb_data_q;
    flag_z_d  = flag_z_q;
    flag_c_d  = flag_c_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          if (op == OP_MUL) begin
            mcand_d  = a;
            mplier_d = b;
            dst_d    = rd_addr;
            acc_d    = '0;
            cnt_d    = '0;
            state_d  = ST_MUL;
          end else begin
            wb_we_d   = 1'b1;
            wb_addr_d = rd_addr;
            wb_data_d = w_alu_res;
            flag_z_d  = (w_alu_res == '0);
            flag_c_d  = w_alu_c;
          end
        end
      end

      ST_MUL: begin
        acc_d    = w_acc_next;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        // The last iteration's sum goes straight to the writeback registers
        // so the pulse lands one cycle after the final iteration.
        if (cnt_q == C_LAST_ITER) begin
          state_d   = ST_IDLE;
          wb_we_d   = 1'b1;
          wb_addr_d = dst_q;
          wb_data_d = w_acc_next[DATA_W-1:0];
          flag_z_d  = (w_acc_next[DATA_W-1:0] == '0);
          flag_c_d  = (w_acc_next[ACC_W-1:DATA_W] != '0);
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      cnt_q     <= '0;
      acc_q     <= '0;
      dst_q     <= '0;
      wb_we_q   <= 1'b0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
      flag_z_q  <= 1'b0;
      flag_c_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      dst_q     <= dst_d;
      wb_we_q   <= wb_we_d;
      wb_addr_q <= wb_addr_d;
      wb_data_q <= wb_data_d;
      flag_z_q  <= flag_z_d;
      flag_c_q  <= flag_c_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign in_ready = (state_q == ST_IDLE);
  assign busy     = (state_q == ST_MUL);
  assign wb_we    = wb_we_q;
  assign wb_addr  = wb_addr_q;
  assign wb_data  = wb_data_q;
  assign flag_z   = flag_z_q;
  assign flag_c   = flag_c_q;

endmodule
`default_nettype wire
